// File: rtl/bmp280_pkg.sv
// BMP280 register map, SPI message helpers and sequencer state encoding.
package bmp280_pkg;

   localparam logic [7:0] REG_ID         = 8'hD0;
   localparam logic [7:0] REG_CONFIG     = 8'hF5;
   localparam logic [7:0] REG_CTRL_MEAS  = 8'hF4;
   localparam logic [7:0] REG_DATA0      = 8'hF7;
   localparam logic [7:0] RD_BIT         = 8'h80;
   localparam logic [7:0] CHIP_ID_BMP280 = 8'h58;
   localparam int unsigned NUM_DATA      = 6;

   typedef enum logic [3:0] {
      StWaitPwr,
      StIdGo,
      StIdWait,
      StCfgGo,
      StCfgWait,
      StMeasGo,
      StMeasWait,
      StIdle,
      StRdGo,
      StRdWait,
      StPublish,
      StPeriod,
      StErr
   } state_e;

   function automatic logic [15:0] rd_msg(input logic [7:0] addr);
      return {addr | RD_BIT, 8'h00};
   endfunction

   function automatic logic [15:0] wr_msg(input logic [7:0] addr, input logic [7:0] data);
      return {addr & ~RD_BIT, data};
   endfunction

endpackage

// File: rtl/bmp280_seq.sv
// BMP280 sequencer: chip-ID check, configuration writes, then periodic single-byte
// reads of the pressure/temperature block driving an external SPI transaction engine.
module bmp280_seq
   import bmp280_pkg::*;
#(
   parameter int unsigned STARTUP_CYCLES = 24000,
   parameter int unsigned PERIOD_CYCLES  = 1200000,
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter logic [7:0]  CONFIG_VAL     = 8'h00,
   parameter logic [7:0]  CTRL_MEAS_VAL  = 8'h27,
   parameter logic [7:0]  CHIP_ID        = CHIP_ID_BMP280
) (
   input  logic        clk12MHz,
   input  logic        rst,
   input  logic        enable,
   output logic        spi_go,
   output logic [15:0] spi_tx,
   input  logic        spi_done,
   input  logic [7:0]  spi_rx,
   output logic [19:0] raw_press,
   output logic [19:0] raw_temp,
   output logic        sample_valid,
   output logic        id_ok,
   output logic        error
);

   localparam int unsigned CntMax = (STARTUP_CYCLES > TIMEOUT_CYCLES) ? STARTUP_CYCLES
                                                                      : TIMEOUT_CYCLES;
   localparam int unsigned CntW   = $clog2(CntMax);
   localparam int unsigned PerW   = $clog2(PERIOD_CYCLES);
   localparam logic [CntW-1:0] StartupLast = CntW'(STARTUP_CYCLES - 1);
   localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
   localparam logic [PerW-1:0] PeriodLast  = PerW'(PERIOD_CYCLES - 1);
   localparam logic [2:0]      IdxLast     = 3'(NUM_DATA - 1);

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [PerW-1:0] per_q;
   logic [2:0]      idx_q;
   logic [7:0]      byte_q [NUM_DATA];
   logic            spi_go_q;
   logic [15:0]     spi_tx_q;
   logic [19:0]     raw_press_q;
   logic [19:0]     raw_temp_q;
   logic            sample_valid_q;
   logic            id_ok_q;
   logic            error_q;
   logic            in_wait;
   logic            timed_out;

   assign in_wait   = state_q inside {StIdWait, StCfgWait, StMeasWait, StRdWait};
   assign timed_out = in_wait && !spi_done && (cnt_q == TimeoutLast);

   always_ff @(posedge clk12MHz) begin
      if (rst) begin
         state_q        <= StWaitPwr;
         cnt_q          <= '0;
         per_q          <= '0;
         idx_q          <= '0;
         spi_go_q       <= 1'b0;
         spi_tx_q       <= '0;
         raw_press_q    <= '0;
         raw_temp_q     <= '0;
         sample_valid_q <= 1'b0;
         id_ok_q        <= 1'b0;
         error_q        <= 1'b0;
         for (int unsigned i = 0; i < NUM_DATA; i++) byte_q[i] <= '0;
      end else begin
         spi_go_q       <= 1'b0;
         sample_valid_q <= 1'b0;
         cnt_q          <= cnt_q + 1'b1;
         // Saturate so an overlong burst leaves the period already expired.
         if (per_q != '1) per_q <= per_q + 1'b1;
         if (timed_out) begin
            state_q <= StErr;
            error_q <= 1'b1;
         end else begin
            unique case (state_q)
               StWaitPwr: if (cnt_q == StartupLast) state_q <= StIdGo;
               StIdGo: begin
                  spi_go_q <= 1'b1;
                  spi_tx_q <= rd_msg(REG_ID);
                  cnt_q    <= '0;
                  state_q  <= StIdWait;
               end
               StIdWait: if (spi_done) begin
                  if (spi_rx == CHIP_ID) begin
                     id_ok_q <= 1'b1;
                     state_q <= StCfgGo;
                  end else begin
                     error_q <= 1'b1;
                     state_q <= StErr;
                  end
               end
               StCfgGo: begin
                  spi_go_q <= 1'b1;
                  spi_tx_q <= wr_msg(REG_CONFIG, CONFIG_VAL);
                  cnt_q    <= '0;
                  state_q  <= StCfgWait;
               end
               StCfgWait: if (spi_done) state_q <= StMeasGo;
               StMeasGo: begin
                  spi_go_q <= 1'b1;
                  spi_tx_q <= wr_msg(REG_CTRL_MEAS, CTRL_MEAS_VAL);
                  cnt_q    <= '0;
                  state_q  <= StMeasWait;
               end
               StMeasWait: if (spi_done) state_q <= StIdle;
               StIdle: if (enable) begin
                  idx_q   <= '0;
                  per_q   <= '0;
                  state_q <= StRdGo;
               end
               StRdGo: begin
                  spi_go_q <= 1'b1;
                  spi_tx_q <= rd_msg(REG_DATA0 + {5'd0, idx_q});
                  cnt_q    <= '0;
                  state_q  <= StRdWait;
               end
               StRdWait: if (spi_done) begin
                  byte_q[idx_q] <= spi_rx;
                  if (idx_q == IdxLast) begin
                     state_q <= StPublish;
                  end else begin
                     idx_q   <= idx_q + 3'd1;
                     state_q <= StRdGo;
                  end
               end
               StPublish: begin
                  raw_press_q    <= {byte_q[0], byte_q[1], byte_q[2][7:4]};
                  raw_temp_q     <= {byte_q[3], byte_q[4], byte_q[5][7:4]};
                  sample_valid_q <= 1'b1;
                  state_q        <= StPeriod;
               end
               StPeriod: if (per_q >= PeriodLast) begin
                  if (enable) begin
                     idx_q   <= '0;
                     per_q   <= '0;
                     state_q <= StRdGo;
                  end else begin
                     state_q <= StIdle;
                  end
               end
               StErr: state_q <= StErr;
               default: begin
                  error_q <= 1'b1;
                  state_q <= StErr;
               end
            endcase
         end
      end
   end

   // Low nibbles of F9/FC are fetched but carry no data for the raw outputs.
   logic unused_low_nibbles;
   assign unused_low_nibbles = ^{byte_q[2][3:0], byte_q[5][3:0]};

   assign spi_go       = spi_go_q;
   assign spi_tx       = spi_tx_q;
   assign raw_press    = raw_press_q;
   assign raw_temp     = raw_temp_q;
   assign sample_valid = sample_valid_q;
   assign id_ok        = id_ok_q;
   assign error        = error_q;

endmodule
